// File: rtl/alu_op_sequencer.sv
// Replays a stored {function,data} micro-program into the sequential ALU: clear, N steps, drain, done.
// start -> done in N+3 cycles; start and program writes are ignored while busy, abort returns to idle.
module alu_op_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [5:0]    prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result,
    output logic [AW:0]   step_idx,
    output logic          alu_reset,
    output logic          alu_en,
    output logic [1:0]    alu_function,
    output logic [3:0]    alu_data,
    input  logic [7:0]    alu_result
);

    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [1:0]  FN_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  mem [DEPTH];
    logic [AW:0] run_len;
    logic [AW:0] next_idx;
    logic [AW:0] len_clamped;

    always_comb begin
        next_idx    = step_idx + (AW+1)'(1);
        len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 8'h00;
            step_idx     <= '0;
            run_len      <= '0;
            alu_reset    <= 1'b0;
            alu_en       <= 1'b0;
            alu_function <= FN_HOLD;
            alu_data     <= 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 6'h00;
            end
        end else begin
            // Program is frozen for the whole run, including the DONE cycle.
            if (state == S_IDLE && prog_we) begin
                mem[prog_addr] <= prog_wdata;
            end

            if (state != S_IDLE && abort) begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                done         <= 1'b0;
                alu_reset    <= 1'b0;
                alu_en       <= 1'b0;
                alu_function <= FN_HOLD;
                alu_data     <= 4'h0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state     <= S_CLEAR;
                            busy      <= 1'b1;
                            alu_reset <= 1'b1;
                            run_len   <= len_clamped;
                            step_idx  <= '0;
                        end
                    end
                    S_CLEAR: begin
                        alu_reset <= 1'b0;
                        if (run_len == '0) begin
                            state <= S_DRAIN;
                        end else begin
                            state                    <= S_RUN;
                            alu_en                   <= 1'b1;
                            {alu_function, alu_data} <= mem[0];
                        end
                    end
                    S_RUN: begin
                        step_idx <= next_idx;
                        if (next_idx >= run_len) begin
                            state        <= S_DRAIN;
                            alu_en       <= 1'b0;
                            alu_function <= FN_HOLD;
                            alu_data     <= 4'h0;
                        end else begin
                            {alu_function, alu_data} <= mem[next_idx[AW-1:0]];
                        end
                    end
                    S_DRAIN: begin
                        // ALU registers its last step at the end of RUN, so ALUout is settled here.
                        result <= alu_result;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
